window_stream_gen: RTL and testbench

- Producer side of the local-extremum window interface.
- Takes a raster pixel stream, one pixel per accepted beat, and buffers windowHW-1 image lines.
- Emits a full windowHW x windowHW neighbourhood, together with the center coordinates, for every pixel position whose window lies completely inside the image.
- Sits between the DoG/scale-space stage and the extremum detector. Valid/ready on both sides.

---
 rtl/window_stream_gen.sv | 148 ++++++++++++++
 tb/tb_window_stream_gen.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_stream_gen.sv
// window_stream_gen
// Producer side of the local-extremum window interface. The block accepts a
// raster pixel stream and keeps windowHW-1 previous image lines in register
// line buffers. For every pixel position whose windowHW x windowHW
// neighbourhood lies fully inside the image, it emits that neighbourhood and
// the coordinates of its center.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   pix_in     input pixel, raster order
//   pix_sof    marks the current pixel as (0,0) of a new frame
//   pix_valid  input beat valid
//   pix_ready  input beat accepted when pix_valid && pix_ready
//   win_out    window, element (r,c) at [(r*windowHW+c)*dataW +: dataW],
//              r=0 is the top (oldest) row, c=0 the leftmost column
//   win_x      center column of the window
//   win_y      center row of the window
//   win_last   window is the last one of the frame
//   win_valid  output valid
//   win_ready  downstream accepts when win_valid && win_ready
module window_stream_gen #(
  parameter int dataW    = 8,
  parameter int windowHW = 3,
  parameter int imgW     = 640,
  parameter int imgH     = 480
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [dataW-1:0]                   pix_in,
  input  logic                               pix_sof,
  input  logic                               pix_valid,
  output logic                               pix_ready,
  output logic [windowHW*windowHW*dataW-1:0] win_out,
  output logic [$clog2(imgW)-1:0]            win_x,
  output logic [$clog2(imgH)-1:0]            win_y,
  output logic                               win_last,
  output logic                               win_valid,
  input  logic                               win_ready
);

  localparam int XW   = $clog2(imgW);
  localparam int YW   = $clog2(imgH);
  localparam int N    = windowHW;
  localparam int L    = windowHW - 1;
  localparam int HALF = (windowHW - 1) / 2;

  // line_buf[0] holds the most recent completed line, line_buf[L-1] the oldest.
  logic [dataW-1:0] line_buf [L][imgW];
  logic [dataW-1:0] win_q    [N][N];
  logic [dataW-1:0] win_next [N][N];

  logic [XW-1:0] col_q;
  logic [YW-1:0] row_q;
  logic [XW-1:0] col_pos;
  logic [YW-1:0] row_pos;
  logic          accept;
  logic          emit;
  logic          pos_last;
  logic          col_end;

  // A single output register: a new beat can enter whenever that register is
  // free or is being drained in the same cycle.
  assign pix_ready = !win_valid || win_ready;
  assign accept    = pix_valid && pix_ready;

  // pix_sof overrides the counters so the flagged pixel is always (0,0).
  always_comb begin
    col_pos  = pix_sof ? '0 : col_q;
    row_pos  = pix_sof ? '0 : row_q;
    col_end  = (col_pos == XW'(imgW - 1));
    pos_last = col_end && (row_pos == YW'(imgH - 1));
    // The column gate also keeps stale left columns of the previous row out
    // of any emitted window; the row gate keeps frames from mixing.
    emit     = accept && (col_pos >= XW'(L)) && (row_pos >= YW'(L));
  end

  // Next window: everything moves one column left, and the new right column
  // is formed from the line buffers at this column (oldest on top) plus the
  // incoming pixel at the bottom.
  always_comb begin
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N - 1; c++) begin
        win_next[r][c] = win_q[r][c+1];
      end
    end
    for (int r = 0; r < N - 1; r++) begin
      win_next[r][N-1] = line_buf[N-2-r][col_pos];
    end
    win_next[N-1][N-1] = pix_in;
  end

  // Line buffers and window shift register carry no reset: their contents are
  // meaningless until enough rows of a frame have been accepted, and the
  // emission gates guarantee that no unwritten entry ever reaches win_out.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = L - 1; k >= 1; k--) begin
        line_buf[k][col_pos] <= line_buf[k-1][col_pos];
      end
      line_buf[0][col_pos] <= pix_in;
      win_q <= win_next;
    end
  end

  // Position counters and the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q     <= '0;
      row_q     <= '0;
      win_valid <= 1'b0;
      win_out   <= '0;
      win_x     <= '0;
      win_y     <= '0;
      win_last  <= 1'b0;
    end else begin
      if (accept) begin
        if (pos_last) begin
          col_q <= '0;
          row_q <= '0;
        end else if (col_end) begin
          col_q <= '0;
          row_q <= row_pos + 1'b1;
        end else begin
          col_q <= col_pos + 1'b1;
          row_q <= row_pos;
        end
      end

      // A new window takes priority: it either fills an empty register or
      // replaces one being accepted downstream in this same cycle.
      if (emit) begin
        win_valid <= 1'b1;
        for (int r = 0; r < N; r++) begin
          for (int c = 0; c < N; c++) begin
            win_out[(r*N+c)*dataW +: dataW] <= win_next[r][c];
          end
        end
        win_x    <= col_pos - XW'(HALF);
        win_y    <= row_pos - YW'(HALF);
        win_last <= pos_last;
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_window_stream_gen.sv
// tb_window_stream_gen
// Directed sequence of streaming scenarios for window_stream_gen on a small
// 5x4 image with a 3x3 window. Expected windows come from a reference model
// that stores the accepted frame as a 2-D image and cuts neighbourhoods out
// of it directly.
module tb_window_stream_gen;

  localparam int DW    = 8;
  localparam int N     = 3;
  localparam int IMG_W = 5;
  localparam int IMG_H = 4;
  localparam int XW    = $clog2(IMG_W);
  localparam int YW    = $clog2(IMG_H);
  localparam int WINW  = N * N * DW;

  logic            clk;
  logic            rst;
  logic [DW-1:0]   pix_in;
  logic            pix_sof;
  logic            pix_valid;
  logic            pix_ready;
  logic [WINW-1:0] win_out;
  logic [XW-1:0]   win_x;
  logic [YW-1:0]   win_y;
  logic            win_last;
  logic            win_valid;
  logic            win_ready;

  window_stream_gen #(
    .dataW   (DW),
    .windowHW(N),
    .imgW    (IMG_W),
    .imgH    (IMG_H)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pix_in   (pix_in),
    .pix_sof  (pix_sof),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .win_out  (win_out),
    .win_x    (win_x),
    .win_y    (win_y),
    .win_last (win_last),
    .win_valid(win_valid),
    .win_ready(win_ready)
  );

  typedef struct {
    logic [WINW-1:0] w;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic            last;
  } win_t;

  win_t          exp_q [$];
  win_t          held;
  logic [DW-1:0] img [IMG_H][IMG_W];
  int            mx = 0;
  int            my = 0;
  bit            stall_prev = 0;
  int            win_count = 0;
  int            last_count = 0;
  int            assert_count = 0;
  int            fail_count = 0;
  int            ready_mode = 0;
  bit            gap_en = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Downstream ready pattern: 0 always, 1 toggle, 2 random, 3 never.
  initial begin
    win_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       win_ready = 1'b1;
        1:       win_ready = ~win_ready;
        2:       win_ready = 1'($urandom_range(0, 1));
        default: win_ready = 1'b0;
      endcase
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model of one accepted pixel: place it in the image at its
  // raster position and, when a full neighbourhood now exists, cut it out.
  task automatic modelAccept(input logic [DW-1:0] p, input logic s);
    win_t e;
    if (s) begin
      mx = 0;
      my = 0;
    end
    img[my][mx] = p;
    if (mx >= N - 1 && my >= N - 1) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          e.w[(r*N+c)*DW +: DW] = img[my-(N-1)+r][mx-(N-1)+c];
      e.x    = XW'(mx - (N - 1) / 2);
      e.y    = YW'(my - (N - 1) / 2);
      e.last = (mx == IMG_W - 1) && (my == IMG_H - 1);
      exp_q.push_back(e);
    end
    if (mx == IMG_W - 1) begin
      mx = 0;
      my = (my == IMG_H - 1) ? 0 : my + 1;
    end else begin
      mx++;
    end
  endtask

  // Observation on the falling edge: values here are what the next rising
  // edge will act on.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      mx = 0;
      my = 0;
      stall_prev = 0;
    end else begin
      checkOutput("valid_vs_model", 128'(win_valid), 128'(exp_q.size() != 0));
      checkOutput("pix_ready", 128'(pix_ready), 128'(!(win_valid && !win_ready)));
      if (stall_prev) begin
        checkOutput("hold_win_out", 128'(win_out), 128'(held.w));
        checkOutput("hold_win_x", 128'(win_x), 128'(held.x));
        checkOutput("hold_win_y", 128'(win_y), 128'(held.y));
        checkOutput("hold_win_last", 128'(win_last), 128'(held.last));
      end
      if (win_valid && win_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_window", 128'(1), 128'(0));
        end else begin
          checkOutput("win_out", 128'(win_out), 128'(exp_q[0].w));
          checkOutput("win_x", 128'(win_x), 128'(exp_q[0].x));
          checkOutput("win_y", 128'(win_y), 128'(exp_q[0].y));
          checkOutput("win_last", 128'(win_last), 128'(exp_q[0].last));
          void'(exp_q.pop_front());
        end
        win_count++;
        if (win_last) last_count++;
      end
      stall_prev = win_valid && !win_ready;
      held.w     = win_out;
      held.x     = win_x;
      held.y     = win_y;
      held.last  = win_last;
      if (pix_valid && pix_ready) modelAccept(pix_in, pix_sof);
    end
  end

  // Present one pixel and hold it until the DUT takes it.
  task automatic applyStimulus(input logic [DW-1:0] p, input logic s);
    bit acc = 0;
    int guard = 0;
    pix_in    = p;
    pix_sof   = s;
    pix_valid = 1'b1;
    while (!acc && guard < 1000) begin
      @(negedge clk);
      acc = pix_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("accept_timeout", 128'(acc), 128'(1));
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    if (gap_en && $urandom_range(0, 2) == 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sendFrame(input bit ramp, input bit sof_first);
    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++)
        applyStimulus(ramp ? DW'(y * 16 + x) : DW'($urandom), sof_first && x == 0 && y == 0);
  endtask

  task automatic drainAndCount(input string tag, input int exp_wins, input int exp_lasts);
    int g = 0;
    while ((exp_q.size() != 0 || win_valid) && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    checkOutput({tag, "_drain"}, 128'(exp_q.size()), 128'(0));
    checkOutput({tag, "_windows"}, 128'(win_count), 128'(exp_wins));
    checkOutput({tag, "_lasts"}, 128'(last_count), 128'(exp_lasts));
    win_count  = 0;
    last_count = 0;
  endtask

  initial begin
    // Reset held for two cycles while pixels are offered.
    rst       = 1'b1;
    pix_valid = 1'b1;
    pix_sof   = 1'b0;
    pix_in    = 8'hA5;
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    pix_valid = 1'b0;
    pix_in    = 8'h00;
    checkOutput("reset_win_valid", 128'(win_valid), 128'(0));
    checkOutput("reset_win_out", 128'(win_out), 128'(0));
    checkOutput("reset_win_x", 128'(win_x), 128'(0));
    checkOutput("reset_win_y", 128'(win_y), 128'(0));
    checkOutput("reset_win_last", 128'(win_last), 128'(0));

    // Frame without sof: the pixels seen during reset must not have moved
    // the counters, so the first pixel is still (0,0).
    $display("[TB] frame after reset, no sof");
    sendFrame(0, 0);
    drainAndCount("post_reset", 6, 1);

    // Ramp image with directed checks around the first window.
    $display("[TB] ramp image, ready high");
    for (int i = 0; i < IMG_W * IMG_H; i++) begin
      applyStimulus(DW'((i / IMG_W) * 16 + (i % IMG_W)), i == 0);
      if (i == 11) checkOutput("no_early_window", 128'(win_valid), 128'(0));
      if (i == 12) begin
        checkOutput("first_valid", 128'(win_valid), 128'(1));
        checkOutput("first_x", 128'(win_x), 128'(1));
        checkOutput("first_y", 128'(win_y), 128'(1));
        checkOutput("first_win", 128'(win_out), 128'(72'h22_21_20_12_11_10_02_01_00));
      end
    end
    drainAndCount("ramp", 6, 1);

    $display("[TB] ramp image, ready toggling");
    ready_mode = 1;
    sendFrame(1, 1);
    drainAndCount("toggle", 6, 1);

    $display("[TB] two random frames, random ready and gaps");
    ready_mode = 2;
    gap_en     = 1;
    sendFrame(0, 1);
    sendFrame(0, 1);
    ready_mode = 0;
    drainAndCount("two_frames", 12, 2);

    $display("[TB] sof after seven pixels");
    ready_mode = 2;
    for (int i = 0; i < 7; i++) applyStimulus(DW'($urandom), i == 0);
    sendFrame(0, 1);
    ready_mode = 0;
    drainAndCount("mid_sof", 6, 1);

    $display("[TB] reset while a window is pending");
    gap_en     = 0;
    ready_mode = 3;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 13; i++) applyStimulus(DW'($urandom), i == 0);
    checkOutput("pending_before_rst", 128'(win_valid), 128'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_drops_valid", 128'(win_valid), 128'(0));
    checkOutput("rst_clears_out", 128'(win_out), 128'(0));
    win_count  = 0;
    last_count = 0;
    ready_mode = 0;
    sendFrame(0, 0);
    drainAndCount("after_rst", 6, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
